saw_period_meter: RTL

SAW_PERIOD_METER -- requirements
Module: saw_period_meter

---
 rtl/synth_pkg.sv | 24 ++
 rtl/saw_step_detect.sv | 27 ++
 rtl/saw_period_meter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the sawtooth period meter.
package synth_pkg;

    typedef enum logic [1:0] {StIdle, StSync, StMeasure, StLocked} meter_state_t;

    typedef enum logic [1:0] {ClsHold, ClsStep, ClsWrap, ClsGlitch} step_class_t;

    localparam int unsigned LOCK_N_FILTER   = 4;
    localparam int unsigned LOCK_N_PLAIN    = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 4095;
    localparam int unsigned CNT_W           = 12;

    // Returns {match, k} for the smallest k in 0..3 with period == base << k.
    function automatic logic [2:0] oct_decode(input logic [CNT_W-1:0] period,
                                              input logic [CNT_W-1:0] base);
        logic [2:0] res;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            if (period == (base << k)) res = {1'b1, 2'(k)};
        end
        return res;
    endfunction

endpackage

// File: rtl/saw_step_detect.sv
// Holds the previous sawtooth sample and classifies each new sample as hold, step, wrap
// or glitch.
module saw_step_detect
    import synth_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_saw,
    output step_class_t o_class
);

    logic [7:0] r_saw_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_saw_q <= '0;
        else          r_saw_q <= i_saw;
    end

    // 255 -> 0 must be a wrap, so it is tested before the 8-bit increment compare.
    always_comb begin
        o_class = ClsGlitch;
        if (i_saw == r_saw_q)                          o_class = ClsHold;
        else if (r_saw_q == 8'hFF && i_saw == 8'h00)   o_class = ClsWrap;
        else if (i_saw == r_saw_q + 8'd1)              o_class = ClsStep;
    end

endmodule

// File: rtl/saw_period_meter.sv
// Sawtooth step-period meter: locks onto a stable step interval and decodes its octave.
// Build option SAW_METER_FILTER_EN: longer lock and tolerance of one isolated mismatch.
module saw_period_meter
    import synth_pkg::*;
#(
    parameter int unsigned COUNTS  = 149,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             enable,
    input  logic [7:0]       saw_in,
    output logic [CNT_W-1:0] step_period,
    output logic [1:0]       oct_dwn,
    output logic             oct_match,
    output logic             locked,
    output logic             err
);

`ifdef SAW_METER_FILTER_EN
    localparam int unsigned LOCK_N   = LOCK_N_FILTER;
    localparam logic        MISS_TOL = 1'b1;
`else
    localparam int unsigned LOCK_N   = LOCK_N_PLAIN;
    localparam logic        MISS_TOL = 1'b0;
`endif
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] COUNTS_C  = CNT_W'(COUNTS);
    localparam logic [2:0]       LOCK_N_C  = 3'(LOCK_N);

    step_class_t      w_class;
    meter_state_t     r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d, r_cand, w_cand_d, r_period;
    logic [2:0]       r_match, w_match_d, w_match_inc, w_oct;
    logic [1:0]       r_oct_dwn;
    logic             r_miss, w_miss_d, r_prev_step, r_err, r_oct_match, w_lock_edge;
    logic             w_step, w_event, w_active, w_timeout, w_fault, w_sample;

    saw_step_detect u_step_detect (
        .i_clk   (clk),
        .i_rst_n (nRst),
        .i_saw   (saw_in),
        .o_class (w_class)
    );

    assign w_step      = (w_class == ClsStep);
    assign w_event     = w_step || (w_class == ClsWrap);
    assign w_active    = (r_state != StIdle);
    // Fires only on the cycle the counter arrives at TIMEOUT, not while it sits saturated.
    assign w_timeout   = !w_event && (r_cnt == TIMEOUT_C - CNT_W'(1));
    assign w_fault     = w_active && ((w_class == ClsGlitch) || w_timeout);
    assign w_sample    = w_step && r_prev_step && (saw_in >= 8'd2) && (saw_in <= 8'd254) &&
                         (r_state == StMeasure || r_state == StLocked);
    assign w_match_inc = r_match + 3'd1;
    assign w_oct       = oct_decode(r_cnt, COUNTS_C);

    always_comb begin
        w_cnt_d = r_cnt;
        if (r_state == StIdle)   w_cnt_d = '0;
        else if (w_event)        w_cnt_d = CNT_W'(1);
        else if (r_cnt < TIMEOUT_C) w_cnt_d = r_cnt + CNT_W'(1);
    end

    always_comb begin
        w_state_d   = r_state;
        w_cand_d    = r_cand;
        w_match_d   = r_match;
        w_miss_d    = r_miss;
        w_lock_edge = 1'b0;
        if (!enable) begin
            w_state_d = StIdle;
        end else if (w_fault) begin
            w_state_d = StSync;
        end else begin
            unique case (r_state)
                StIdle: w_state_d = StSync;
                StSync: begin
                    if (w_step) begin
                        w_state_d = StMeasure;
                        w_cand_d  = '0;
                        w_match_d = '0;
                        w_miss_d  = 1'b0;
                    end
                end
                StMeasure: begin
                    if (w_sample) begin
                        if (r_cnt == r_cand) begin
                            w_match_d = w_match_inc;
                            if (w_match_inc == LOCK_N_C) begin
                                w_state_d   = StLocked;
                                w_lock_edge = 1'b1;
                                w_miss_d    = 1'b0;
                            end
                        end else begin
                            w_cand_d  = r_cnt;
                            w_match_d = 3'd1;
                        end
                    end
                end
                StLocked: begin
                    if (w_sample) begin
                        if (r_cnt == r_period) begin
                            w_miss_d = 1'b0;
                        end else if (MISS_TOL && !r_miss) begin
                            w_miss_d = 1'b1;
                        end else begin
                            w_state_d = StMeasure;
                            w_cand_d  = r_cnt;
                            w_match_d = 3'd1;
                            w_miss_d  = 1'b0;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_match     <= '0;
            r_miss      <= 1'b0;
            r_prev_step <= 1'b0;
            r_err       <= 1'b0;
            r_period    <= '0;
            r_oct_dwn   <= '0;
            r_oct_match <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cand  <= w_cand_d;
            r_match <= w_match_d;
            r_miss  <= w_miss_d;
            r_err   <= enable && w_fault;
            if (r_state == StIdle)         r_prev_step <= 1'b0;
            else if (w_step)               r_prev_step <= 1'b1;
            else if (w_class != ClsHold)   r_prev_step <= 1'b0;
            if (w_lock_edge) begin
                r_period    <= r_cnt;
                r_oct_match <= w_oct[2];
                r_oct_dwn   <= w_oct[1:0];
            end
        end
    end

    assign step_period = r_period;
    assign oct_dwn     = r_oct_dwn;
    assign oct_match   = r_oct_match;
    assign locked      = (r_state == StLocked);
    assign err         = r_err;

endmodule
